gmem_responder: RTL and testbench

Multi-channel global-memory responder: the memory side of the `mem_*` valid/ready interface driven by the data/program memory controllers. Each of NUM_CHANNELS channels accepts one read or write request at a time, models a fixed access latency, then arbitrates for a single-ported backing array. It answers with a one-cycle ready pulse and, for reads, the returned data. It serves as the simulation memory model and as the on-chip scratch memory in small builds.

---
 rtl/gmem_responder.sv | 215 +++++++++++++++++++++
 tb/tb_gmem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gmem_responder.sv
// gmem_responder: multi-channel global-memory responder.
// Each channel accepts one read or write, waits a fixed latency, then
// competes for a single-ported backing array and answers with a one-cycle
// ready pulse (plus read data for reads). A backdoor load port preloads
// storage and always wins the array over the channels.
// Optional feature macro: GMEM_RR_ARB_EN selects round-robin arbitration;
// when undefined, the lowest-index requesting channel wins.
module gmem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready,
    input  logic                    load_valid,
    input  logic [ADDR_BITS-1:0]    load_address,
    input  logic [DATA_BITS-1:0]    load_data
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ARB,
        ST_RESP,
        ST_COOLDOWN
    } state_t;

    // Per-channel request view exported to the arbiter / storage path
    logic [NUM_CHANNELS-1:0] arb_req;
    logic [NUM_CHANNELS-1:0] grant;
    logic [NUM_CHANNELS-1:0] ch_op;
    logic [ADDR_BITS-1:0]    ch_addr  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    ch_wdata [NUM_CHANNELS];

    logic                    gnt_any;
    logic [IDX_W-1:0]        gnt_idx;
    logic [ADDR_BITS-1:0]    gnt_addr;
    logic [DATA_BITS-1:0]    gnt_wdata;
    logic                    gnt_op;

    logic [DATA_BITS-1:0]    mem_q       [DEPTH];
    logic [DATA_BITS-1:0]    read_data_q [NUM_CHANNELS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            state_t               state_q, state_d;
            logic [CNT_W-1:0]     cnt_q, cnt_d;
            logic [ADDR_BITS-1:0] addr_q, addr_d;
            logic [DATA_BITS-1:0] wdata_q, wdata_d;
            logic                 op_q, op_d;

            // Channel request registers; reset drops any in-flight request
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                    op_q    <= OP_READ;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    addr_q  <= addr_d;
                    wdata_q <= wdata_d;
                    op_q    <= op_d;
                end
            end

            // Channel FSM: accept (read wins), count latency, arbitrate, respond, cool down
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                addr_d  = addr_q;
                wdata_d = wdata_q;
                op_d    = op_q;
                case (state_q)
                    ST_IDLE: begin
                        if (mem_read_valid[gi]) begin
                            addr_d  = mem_read_address[gi];
                            op_d    = OP_READ;
                            cnt_d   = CNT_W'(LATENCY - 1);
                            state_d = ST_WAIT;
                        end else if (mem_write_valid[gi]) begin
                            addr_d  = mem_write_address[gi];
                            wdata_d = mem_write_data[gi];
                            op_d    = OP_WRITE;
                            cnt_d   = CNT_W'(LATENCY - 1);
                            state_d = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_q == '0) begin
                            state_d = ST_ARB;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    ST_ARB: begin
                        if (grant[gi]) begin
                            state_d = ST_RESP;
                        end
                    end
                    ST_RESP:     state_d = ST_COOLDOWN;
                    ST_COOLDOWN: state_d = ST_IDLE;
                    default:     state_d = ST_IDLE;
                endcase
            end

            assign arb_req[gi]         = (state_q == ST_ARB);
            assign ch_op[gi]           = op_q;
            assign ch_addr[gi]         = addr_q;
            assign ch_wdata[gi]        = wdata_q;
            assign grant[gi]           = gnt_any && (gnt_idx == IDX_W'(gi));
            assign mem_read_ready[gi]  = (state_q == ST_RESP) && (op_q == OP_READ);
            assign mem_write_ready[gi] = (state_q == ST_RESP) && (op_q == OP_WRITE);
            assign mem_read_data[gi]   = read_data_q[gi];
        end
    endgenerate

`ifdef GMEM_RR_ARB_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Round-robin pick starting at the pointer; a load cycle grants nobody
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        // Walk offsets from far to near so the nearest requester is kept
        for (int off = NUM_CHANNELS - 1; off >= 0; off--) begin
            idx = (int'(ptr_q) + off) % NUM_CHANNELS;
            if (arb_req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
        if (load_valid) begin
            gnt_any = 1'b0;
        end
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority pick: lowest requesting index; a load cycle grants nobody
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (arb_req[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
        if (load_valid) begin
            gnt_any = 1'b0;
        end
    end
`endif

    assign gnt_addr  = ch_addr[gnt_idx];
    assign gnt_wdata = ch_wdata[gnt_idx];
    assign gnt_op    = ch_op[gnt_idx];

    // Single storage port: load first, otherwise the granted channel's access
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                read_data_q[c] <= '0;
            end
        end else if (load_valid) begin
            mem_q[load_address] <= load_data;
        end else if (gnt_any) begin
            if (gnt_op == OP_WRITE) begin
                if (WRITE_ENABLE != 0) begin
                    mem_q[gnt_addr] <= gnt_wdata;
                end
            end else begin
                read_data_q[gnt_idx] <= mem_q[gnt_addr];
            end
        end
    end

endmodule

// File: tb/tb_gmem_responder.sv
// tb_gmem_responder: directed checks of gmem_responder with default
// parameters, plus a WRITE_ENABLE=0 copy sharing the same inputs.
module tb_gmem_responder;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] rv, wv, rr, wr, rr_nw, wr_nw;
    logic [7:0]     raddr [NCH];
    logic [7:0]     waddr [NCH];
    logic [7:0]     wdata [NCH];
    logic [7:0]     rdata [NCH];
    logic [7:0]     rdata_nw [NCH];
    logic           load_valid;
    logic [7:0]     load_address, load_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gmem_responder #(.WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv), .mem_read_address(raddr),
        .mem_read_ready(rr), .mem_read_data(rdata),
        .mem_write_valid(wv), .mem_write_address(waddr),
        .mem_write_data(wdata), .mem_write_ready(wr),
        .load_valid(load_valid), .load_address(load_address), .load_data(load_data)
    );

    gmem_responder #(.WRITE_ENABLE(0)) dut_nowe (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv), .mem_read_address(raddr),
        .mem_read_ready(rr_nw), .mem_read_data(rdata_nw),
        .mem_write_valid(wv), .mem_write_address(waddr),
        .mem_write_data(wdata), .mem_write_ready(wr_nw),
        .load_valid(load_valid), .load_address(load_address), .load_data(load_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        load_valid   = 1'b1;
        load_address = a;
        load_data    = d;
        tick();
        load_valid   = 1'b0;
    endtask

    task automatic preload_all();
        load(8'h10, 8'hA5);
        load(8'h30, 8'h11);
        load(8'h31, 8'h22);
        load(8'h32, 8'h33);
        load(8'h33, 8'h44);
        load(8'h40, 8'h77);
        load(8'h50, 8'h66);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [3:0] exp_vec;
    logic [3:0] first_ch;

    initial begin
        reset = 1'b1; rv = '0; wv = '0;
        load_valid = 1'b0; load_address = '0; load_data = '0;
        for (int i = 0; i < NCH; i++) begin
            raddr[i] = '0; waddr[i] = '0; wdata[i] = '0;
        end

        // Reset state
        tick(); tick();
        check("reset_rready", 32'(rr), 32'(0));
        check("reset_wready", 32'(wr), 32'(0));
        for (int i = 0; i < NCH; i++) check("reset_rdata", 32'(rdata[i]), 32'(0));
        reset = 1'b0;
        preload_all();

        // Single read, latency 2: ready only at t+4
        raddr[0] = 8'h10; rv[0] = 1'b1; tick(); rv[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("t1_rready", 32'(rr), (k == 4) ? 32'(1) : 32'(0));
            if (k >= 4) check("t1_rdata", 32'(rdata[0]), 32'(8'hA5));
            tick();
        end

        // ch1 write then read back; no-write-enable copy keeps 0
        waddr[1] = 8'h20; wdata[1] = 8'h3C; wv[1] = 1'b1; tick(); wv[1] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check("t2_wready", 32'(wr), (k == 4) ? 32'(2) : 32'(0));
            if (k == 4) check("t2_wready_nowe", 32'(wr_nw), 32'(2));
            tick();
        end
        raddr[1] = 8'h20; rv[1] = 1'b1; tick(); rv[1] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("t2_rready", 32'(rr), (k == 4) ? 32'(2) : 32'(0));
            if (k == 4) begin
                check("t2_rdata", 32'(rdata[1]), 32'(8'h3C));
                check("t2_rdata_nowe", 32'(rdata_nw[1]), 32'(8'h00));
            end
            tick();
        end

        // All four channels at once, twice: one ready per cycle, order 0..3
        do_reset();
        preload_all();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NCH; i++) raddr[i] = 8'h30 + 8'(i);
            rv = 4'hF; tick(); rv = 4'h0;
            for (int k = 1; k <= 9; k++) begin
                exp_vec = (k >= 4 && k <= 7) ? 4'(1 << (k - 4)) : 4'h0;
                check("t3_rready", 32'(rr), 32'(exp_vec));
                if (k >= 4 && k <= 7)
                    check("t3_rdata", 32'(rdata[k - 4]), 32'(8'h11 * (k - 3)));
                tick();
            end
        end

        // Policy: after a ch2 grant, ch0 vs ch3 contend
        raddr[2] = 8'h32; rv = 4'b0100; tick(); rv = 4'h0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) check("t4_solo_rready", 32'(rr), 32'(4'b0100));
            tick();
        end
        raddr[0] = 8'h30; raddr[3] = 8'h33; rv = 4'b1001; tick(); rv = 4'h0;
`ifdef GMEM_RR_ARB_EN
        first_ch = 4'b1000;
`else
        first_ch = 4'b0001;
`endif
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) check("t4_first", 32'(rr), 32'(first_ch));
            if (k == 5) check("t4_second", 32'(rr), 32'(4'b1001 & ~first_ch));
            if (k == 5) check("t4_rdata3", 32'(rdata[3]), 32'(8'h44));
            tick();
        end

        // Load priority: two load cycles during ch2 ARB delay ready by two
        raddr[2] = 8'h40; rv = 4'b0100; tick(); rv = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            check("t5_rready", 32'(rr), (k == 6) ? 32'(4'b0100) : 32'(0));
            if (k == 6) check("t5_rdata", 32'(rdata[2]), 32'(8'h5A));
            if (k == 3) begin
                load_valid = 1'b1; load_address = 8'h40; load_data = 8'h5A;
            end
            if (k == 5) load_valid = 1'b0;
            tick();
        end

        // Read and write both valid on ch0: read first, write after cooldown
        raddr[0] = 8'h50; waddr[0] = 8'h50; wdata[0] = 8'h99;
        rv[0] = 1'b1; wv[0] = 1'b1; tick();
        for (int k = 1; k <= 10; k++) begin
            check("t6_rready", 32'(rr), (k == 4) ? 32'(1) : 32'(0));
            check("t6_wready", 32'(wr), (k == 10) ? 32'(1) : 32'(0));
            if (k == 4) begin
                check("t6_rdata", 32'(rdata[0]), 32'(8'h66));
                rv[0] = 1'b0;
            end
            if (k == 10) wv[0] = 1'b0;
            tick();
        end
        tick();
        rv[0] = 1'b1; tick(); rv[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 4) begin
                check("t6_rb_rready", 32'(rr), 32'(1));
                check("t6_rb_rdata", 32'(rdata[0]), 32'(8'h99));
                check("t6_rb_rdata_nowe", 32'(rdata_nw[0]), 32'(8'h66));
            end
            tick();
        end

        // Reset during WAIT: request dropped, storage cleared, held valid re-served
        load(8'h60, 8'hEE);
        raddr[0] = 8'h60; rv[0] = 1'b1; tick();
        reset = 1'b1; tick();
        check("t7_reset_rready", 32'(rr), 32'(0));
        check("t7_reset_rdata", 32'(rdata[0]), 32'(0));
        reset = 1'b0;
        tick();
        for (int k = 1; k <= 5; k++) begin
            check("t7_rready", 32'(rr), (k == 4) ? 32'(1) : 32'(0));
            if (k == 4) begin
                check("t7_rdata", 32'(rdata[0]), 32'(8'h00));
                rv[0] = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
